// File: rtl/hsio_pattern_gen.sv
// hsio_pattern_gen: multi-channel clock-divided pad pattern generator (static/walk/counter/LFSR).
// Define HSIO_PATGEN_TRISTATE_EN to drive per-channel tristate from the latched cfg_oe.
module hsio_pattern_gen #(
  parameter int          NCH       = 8,
  parameter int          DIV_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [NCH-1:0]   cfg_static,
  input  logic [NCH-1:0]   cfg_oe,
  input  logic             run,
  output logic [NCH-1:0]   q,
  output logic [NCH-1:0]   t,
  output logic             step,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state, state_nx;
  logic [1:0] mode;
  logic [DIV_W-1:0] div, presc;
  logic [NCH-1:0] stat, init_q, adv_q;
  logic [15:0] lfsr, lfsr_nx;
  logic accept, adv, adv_wrap;
  assign cfg_ready = state != RUN;
  always_comb begin
    accept = cfg_valid & cfg_ready;
    adv = (state == RUN) & run & (presc == '0);
    lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    init_q = cfg_mode == 2'd0 ? cfg_static :
             cfg_mode == 2'd1 ? NCH'(1) :
             cfg_mode == 2'd2 ? '0 : LFSR_SEED[NCH-1:0];
    adv_q = mode == 2'd0 ? stat :
            mode == 2'd1 ? ((q << 1) | (q >> (NCH - 1))) :
            mode == 2'd2 ? q + NCH'(1) : lfsr_nx[NCH-1:0];
    adv_wrap = (mode == 2'd0) | ((mode == 2'd1) & q[NCH-1]) |
               ((mode == 2'd2) & (&q)) | ((mode == 2'd3) & (lfsr_nx == LFSR_SEED));
    // a config in ARM beats a simultaneous run request
    state_nx = accept ? ARM :
               (state == ARM && run) ? RUN :
               (state == RUN && !run) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode  <= '0;
      div   <= '0;
      stat  <= '0;
      presc <= '0;
      lfsr  <= LFSR_SEED;
      q     <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      step  <= adv;
      wrap  <= adv & adv_wrap;
      if (accept) begin
        mode  <= cfg_mode;
        div   <= cfg_div;
        stat  <= cfg_static;
        presc <= cfg_div;
        lfsr  <= LFSR_SEED;
        q     <= init_q;
      end else if (state == RUN && run) begin
        presc <= adv ? div : presc - DIV_W'(1);
        if (adv) begin
          q    <= adv_q;
          lfsr <= lfsr_nx;
        end
      end
    end
  end
`ifdef HSIO_PATGEN_TRISTATE_EN
  logic [NCH-1:0] oe;
  always_ff @(posedge clk) begin
    if (rst) oe <= '0;
    else if (accept) oe <= cfg_oe;
  end
  assign t = state == IDLE ? '1 : ~oe;
`else
  logic unused_oe;
  assign unused_oe = ^cfg_oe;
  assign t = '0;
`endif
endmodule

// File: tb/tb_hsio_pattern_gen.sv
// tb_hsio_pattern_gen: randomized scoreboard bench for hsio_pattern_gen against a step-indexed model.
module tb_hsio_pattern_gen;
  localparam int NCH = 8;
  localparam int DIV_W = 8;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef HSIO_PATGEN_TRISTATE_EN
  localparam bit TRI = 1'b1;
`else
  localparam bit TRI = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, run = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [NCH-1:0] cfg_static = '0, cfg_oe = '0;
  logic cfg_ready, step, wrap;
  logic [NCH-1:0] q, t;
  hsio_pattern_gen #(.NCH(NCH), .DIV_W(DIV_W), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_div(cfg_div), .cfg_static(cfg_static), .cfg_oe(cfg_oe), .run(run),
    .q(q), .t(t), .step(step), .wrap(wrap));
  always #5 clk = ~clk;
  typedef struct packed { logic [NCH-1:0] q; logic w; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  int steps_seen = 0, wraps_seen = 0, target = 0, cyc = 0, last_step = -1, gap = 1;
  int m_k, m_mode;
  logic [15:0] m_l;
  logic [NCH-1:0] m_stat, m_oe;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // monitor: pops one expected pattern per step pulse
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (wrap && !step) chk("wrap_without_step", 1, 0);
    if (step) begin
      steps_seen++;
      if (wrap) wraps_seen++;
      if (sb.size() == 0) chk("unexpected_step", 1, 0);
      else begin
        e = sb.pop_front();
        chk("q_on_step", q, e.q);
        chk("wrap_on_step", wrap, e.w);
      end
      if (last_step >= 0) chk("step_period", cyc - last_step, gap);
      last_step = cyc;
    end
  end
  function automatic logic [NCH-1:0] init_pattern(input int mode, input logic [NCH-1:0] s);
    return mode == 0 ? s : mode == 1 ? NCH'(1) : mode == 2 ? NCH'(0) : SEED[NCH-1:0];
  endfunction
  // reference: the k-th advance of each pattern expressed directly by step index
  task automatic model_push(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      m_k++;
      case (m_mode)
        0: begin e.q = m_stat; e.w = 1'b1; end
        1: begin e.q = NCH'(1) << (m_k % NCH); e.w = (m_k % NCH) == 0; end
        2: begin e.q = NCH'(m_k % (1 << NCH)); e.w = (m_k % (1 << NCH)) == 0; end
        default: begin
          m_l = {m_l[14:0], ^(m_l & 16'hB400)};
          e.q = m_l[NCH-1:0];
          e.w = m_l == SEED;
        end
      endcase
      sb.push_back(e);
    end
  endtask
  task automatic configure(input int mode, input int div, input logic [NCH-1:0] s, input logic [NCH-1:0] oe);
    @(negedge clk);
    cfg_mode = 2'(mode); cfg_div = DIV_W'(div); cfg_static = s; cfg_oe = oe; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    m_mode = mode; m_stat = s; m_oe = oe; m_k = 0; m_l = SEED;
    sb.delete(); steps_seen = 0; wraps_seen = 0; target = 0; last_step = -1; gap = div + 1;
    chk("arm_q_init", q, init_pattern(mode, s));
    chk("arm_ready", cfg_ready, 1);
    chk("arm_t", t, TRI ? ~oe : '0);
  endtask
  task automatic go(input int n);
    int c = 0;
    model_push(n);
    target += n;
    run = 1'b1;
    while (steps_seen < target && c < n * gap + 8) begin
      @(negedge clk);
      c++;
    end
    if (steps_seen < target) chk("step_timeout", steps_seen, target);
  endtask
  task automatic stop();
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_step", step, 0);
    chk("idle_ready", cfg_ready, 1);
    chk("idle_t", t, TRI ? '1 : '0);
    chk("sb_drained", sb.size(), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_step", step, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_t", t, TRI ? '1 : '0);
    rst = 1'b0;
    // walk, div 0: wrap lands on 80->01
    configure(1, 0, '0, 8'h0F);
    go(9);
    chk("run_t", t, TRI ? 8'hF0 : 8'h00);
    chk("run_ready", cfg_ready, 0);
    stop();
    chk("walk_wraps", wraps_seen, 1);
    // abort at q=10 holds the pattern
    configure(1, 0, '0, '1);
    go(4);
    stop();
    chk("abort_hold_q", q, 8'h10);
    // counter div 3 through a full wrap, with an ignored config mid-run
    configure(2, 3, '0, 8'hA5);
    go(5);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_div = 8'd0;
    chk("run_ready_blocks_cfg", cfg_ready, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    go(251);
    chk("counter_wraps", wraps_seen, 1);
    chk("counter_wrap_q", q, 0);
    stop();
    // config beats run rising in ARM
    configure(3, 0, '0, '0);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_mode = 2'd2; run = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; run = 1'b0;
    chk("cfg_wins_ready", cfg_ready, 1);
    chk("cfg_wins_q", q, 0);
    chk("cfg_wins_step", step, 0);
    // reset during RUN
    configure(2, 0, '0, '0);
    go(6);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("midrun_rst_q", q, 0);
    chk("midrun_rst_step", step, 0);
    chk("midrun_rst_ready", cfg_ready, 1);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    sb.delete();
    // randomized configurations
    for (int r = 0; r < 8; r++) begin
      configure($urandom_range(0, 3), $urandom_range(0, 3), NCH'($urandom), NCH'($urandom));
      go($urandom_range(5, 40));
      stop();
    end
    // LFSR full period
    configure(3, 0, '0, '0);
    go(65535);
    chk("lfsr_wraps", wraps_seen, 1);
    chk("lfsr_wrap_q", q, SEED[NCH-1:0]);
    stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
